// File: rtl/button_debounce_sync_if.sv
// Key-side signal bundle for one debounced push-button instance.
// master drives the raw key and counter clear; slave is the debouncer.
`timescale 1ns/1ps
interface button_debounce_sync_if #(
    parameter int PCNT_W = 16
);
    logic              btn_raw;
    logic              count_clr;
    logic              btn_level;
    logic              press_pulse;
    logic              release_pulse;
    logic [PCNT_W-1:0] press_count;

    modport master (
        output btn_raw,
        output count_clr,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  press_count
    );

    modport slave (
        input  btn_raw,
        input  count_clr,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output press_count
    );
endinterface

// File: rtl/button_debounce_sync.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM with registered
// level/press/release outputs, and a wrap-around press counter.
`timescale 1ns/1ps
module button_debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int PCNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    button_debounce_sync_if.slave bus
);

    localparam logic             INVERT   = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                s1_q, s1_d;
    logic                s2_q, s2_d;
    logic                level_q, level_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic [PCNT_W-1:0]   press_count_q, press_count_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RELEASED;
            cnt_q         <= '0;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            level_q       <= 1'b0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            level_q       <= level_d;
            press_q       <= press_d;
            release_q     <= release_d;
            press_count_q <= press_count_d;
        end
    end

    always_comb begin
        s1_d          = bus.btn_raw ^ INVERT;
        s2_d          = s1_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        level_d       = level_q;
        press_d       = 1'b0;
        release_d     = 1'b0;
        press_count_d = press_count_q;

        // Only s2_q is trusted; a disagreeing sample during a pending state aborts it.
        case (state_q)
            RELEASED: begin
                cnt_d = '0;
                if (s2_q) begin
                    state_d = PRESS_PENDING;
                end
            end
            PRESS_PENDING: begin
                if (!s2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!s2_q) begin
                    state_d = RELEASE_PENDING;
                end
            end
            RELEASE_PENDING: begin
                if (s2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        // Clear wins over a press accepted on the same edge.
        if (bus.count_clr) begin
            press_count_d = '0;
        end else if (press_d) begin
            press_count_d = press_count_q + 1'b1;
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.press_count   = press_count_q;

endmodule
